dmem_lsu: RTL and testbench

Parametrised data-memory and MMIO load/store unit for the RV32 core. It replaces the single-cycle combinational data memory with a valid/ready request channel, a registered one-cycle response and a configurable memory depth and output-register count. Misaligned, unmapped and illegal accesses are reported as errors, and switch inputs are synchronised. It sits between the core's MEM stage and the board I/O (LEDs, HEX, LCD, switches).

---
 rtl/dmem_lsu.sv | 157 +++++++++++++++
 tb/tb_dmem_lsu.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_lsu.sv
// Data-memory and MMIO load/store unit for the RV32 core.
// Requests are taken on a valid/ready channel. Each request produces one
// registered response. The address space has three regions: data memory,
// output registers and the synchronised switch word.
//
// Handshake rules, which apply to both channels:
// a transfer happens on a rising edge where valid && ready. A held response
// keeps valid, rdata and err stable until rsp_ready_i takes it. The request
// side is ready whenever the response slot is empty or is being drained in
// the same cycle.
module dmem_lsu #(
  parameter int          DEPTH_W  = 9,
  parameter int          N_OUT    = 11,
  parameter logic [31:0] MEM_BASE = 32'h0000_0000,
  parameter logic [31:0] OUT_BASE = 32'h0000_0800,
  parameter logic [31:0] IN_BASE  = 32'h0000_0900
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [1:0]           req_size_i,
  input  logic                 req_unsigned_i,
  input  logic [31:0]          req_addr_i,
  input  logic [31:0]          req_wdata_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [31:0]          rsp_rdata_o,
  output logic                 rsp_err_o,
  input  logic [31:0]          io_sw_i,
  output logic [32*N_OUT-1:0]  io_out_o
);

  localparam int          MEM_WORDS = 1 << DEPTH_W;
  localparam logic [32:0] MEM_BYTES = 33'(4 * MEM_WORDS);
  localparam logic [32:0] OUT_BYTES = 33'(4 * N_OUT);
  localparam int          OUT_IW    = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  logic [31:0] mem [MEM_WORDS];
  logic [31:0] out_r [N_OUT];
  logic [31:0] sw_meta, sw_sync;

  logic        rsp_valid_q, rsp_err_q;
  logic [31:0] rsp_rdata_q;

  logic [32:0]        mem_off, out_off;
  logic [DEPTH_W-1:0] mem_idx;
  logic [OUT_IW-1:0]  out_idx;
  logic               sel_mem, sel_out, sel_in, misaligned, err, accept, wr_ok;
  logic [3:0]         be;
  logic [31:0]        wdata_rep, word, lane, ld_data;

  assign req_ready_o = !rsp_valid_q || rsp_ready_i;
  assign accept      = req_valid_i && req_ready_o && rst_ni;
  assign wr_ok       = accept && req_we_i && !err;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

  // Decode the region, check the access and build the lane enables and load data.
  // Offsets are taken in 33 bits so an address below a base wraps to a huge
  // value and fails the range test. Regions are selected with priority
  // MEM, then OUT, then IN.
  always_comb begin
    mem_off    = {1'b0, req_addr_i} - {1'b0, MEM_BASE};
    out_off    = {1'b0, req_addr_i} - {1'b0, OUT_BASE};
    mem_idx    = DEPTH_W'(mem_off >> 2);
    out_idx    = OUT_IW'(out_off >> 2);
    sel_mem    = mem_off < MEM_BYTES;
    sel_out    = !sel_mem && (out_off < OUT_BYTES);
    sel_in     = !sel_mem && !sel_out && (req_addr_i[31:2] == IN_BASE[31:2]);
    misaligned = (req_size_i == 2'b11) ||
                 (req_size_i == 2'b01 && req_addr_i[0]) ||
                 (req_size_i == 2'b10 && req_addr_i[1:0] != 2'b00);
    err        = misaligned || !(sel_mem || sel_out || sel_in) || (req_we_i && sel_in);

    be        = 4'b0000;
    wdata_rep = req_wdata_i;
    case (req_size_i)
      2'b00: begin
        be        = 4'b0001 << req_addr_i[1:0];
        wdata_rep = {4{req_wdata_i[7:0]}};
      end
      2'b01: begin
        be        = req_addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{req_wdata_i[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase

    word = '0;
    if (sel_mem)      word = mem[mem_idx];
    else if (sel_out) word = out_r[out_idx];
    else if (sel_in)  word = sw_sync;
    lane = word >> {req_addr_i[1:0], 3'b000};

    case (req_size_i)
      2'b00:   ld_data = req_unsigned_i ? {24'h0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
      2'b01:   ld_data = req_unsigned_i ? {16'h0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      default: ld_data = word;
    endcase
  end

  // Data memory byte-lane writes. The memory is deliberately not reset.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_ok && sel_mem && be[b]) mem[mem_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
    end
  end

  // Output peripheral registers, cleared on reset and written per byte lane.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int k = 0; k < N_OUT; k++) out_r[k] <= '0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (wr_ok && sel_out && be[b]) out_r[out_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
      end
    end
  end

  // Two-flop synchroniser for the asynchronous switch inputs.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= io_sw_i;
      sw_sync <= sw_meta;
    end
  end

  // Response slot: load on accept (this may retire the old response in the
  // same cycle), otherwise drain it on rsp_ready_i.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else if (accept) begin
      rsp_valid_q <= 1'b1;
      rsp_rdata_q <= (err || req_we_i) ? 32'h0 : ld_data;
      rsp_err_q   <= err;
    end else if (rsp_ready_i) begin
      rsp_valid_q <= 1'b0;
    end
  end

  // Flatten the output registers onto the board bus.
  always_comb begin
    io_out_o = '0;
    for (int k = 0; k < N_OUT; k++) io_out_o[32*k +: 32] = out_r[k];
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu. It runs a directed sequence of literal expectations,
// then randomized traffic. A behavioural model checks the DUT on every cycle.
module tb_dmem_lsu;

  localparam int          DEPTH_W  = 9;
  localparam int          N_OUT    = 11;
  localparam longint      MEM_B    = 64'h0;
  localparam longint      MEM_E    = 64'h800;
  localparam longint      OUT_B    = 64'h800;
  localparam longint      OUT_E    = 64'h800 + 4 * N_OUT;
  localparam logic [31:0] OUT_BASE = 32'h0000_0800;
  localparam logic [31:0] IN_BASE  = 32'h0000_0900;

  logic                clk, rst_n;
  logic                req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]          req_size;
  logic [31:0]         req_addr, req_wdata;
  logic                rsp_valid, rsp_ready, rsp_err;
  logic [31:0]         rsp_rdata, io_sw;
  logic [32*N_OUT-1:0] io_out;

  dmem_lsu #(
    .DEPTH_W(DEPTH_W), .N_OUT(N_OUT), .MEM_BASE(32'h0),
    .OUT_BASE(OUT_BASE), .IN_BASE(IN_BASE)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_size_i(req_size), .req_unsigned_i(req_unsigned),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .io_sw_i(io_sw), .io_out_o(io_out)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_mem [2**DEPTH_W];
  logic [31:0] m_out [N_OUT];
  logic [31:0] m_sw_q[$];     // switch values sampled at the last two edges
  logic [32:0] exp_q[$];      // pending response {err, rdata}

  initial begin
    for (int i = 0; i < 2**DEPTH_W; i++) m_mem[i] = '0;
    for (int k = 0; k < N_OUT; k++) m_out[k] = '0;
    m_sw_q = '{32'h0, 32'h0};
  end

  // Region 0 = MEM, 1 = OUT, 2 = IN, 3 = unmapped.
  function automatic logic [32:0] model_access(input logic we, input logic [1:0] size,
                                               input logic uns, input logic [31:0] addr,
                                               input logic [31:0] wdata, input logic [31:0] sw);
    longint      a = longint'(addr);
    int          region, nbytes, pos;
    logic [31:0] w, v;
    if (a >= MEM_B && a < MEM_E)                region = 0;
    else if (a >= OUT_B && a < OUT_E)           region = 1;
    else if (addr[31:2] == IN_BASE[31:2])       region = 2;
    else                                        region = 3;
    nbytes = 1 << size;
    if (size == 2'd3 || (a % nbytes) != 0 || region == 3 || (we && region == 2))
      return {1'b1, 32'h0};
    case (region)
      0:       w = m_mem[int'((a - MEM_B) / 4)];
      1:       w = m_out[int'((a - OUT_B) / 4)];
      default: w = sw;
    endcase
    if (we) begin
      for (int i = 0; i < nbytes; i++) begin
        pos = int'(a % 4) + i;
        w[8*pos +: 8] = wdata[8*i +: 8];
      end
      if (region == 0) m_mem[int'((a - MEM_B) / 4)] = w;
      else             m_out[int'((a - OUT_B) / 4)] = w;
      return {1'b0, 32'h0};
    end
    v = '0;
    for (int i = 0; i < nbytes; i++) begin
      pos = int'(a % 4) + i;
      v[8*i +: 8] = w[8*pos +: 8];
    end
    if (!uns && nbytes < 4 && v[8*nbytes-1]) v = v | ~((32'h1 << (8*nbytes)) - 32'h1);
    return {1'b0, v};
  endfunction

  // Advance the model at each rising edge using the inputs driven before it.
  always @(posedge clk) begin : model
    logic ready;
    if (!rst_n) begin
      exp_q.delete();
      for (int k = 0; k < N_OUT; k++) m_out[k] = '0;
      m_sw_q = '{32'h0, 32'h0};
    end else begin
      ready = (exp_q.size() == 0) || rsp_ready;
      if (exp_q.size() != 0 && rsp_ready) void'(exp_q.pop_front());
      if (req_valid && ready)
        exp_q.push_back(model_access(req_we, req_size, req_unsigned, req_addr, req_wdata, m_sw_q[0]));
      void'(m_sw_q.pop_front());
      m_sw_q.push_back(io_sw);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check("rsp_valid", 32'(rsp_valid), 32'(exp_q.size() != 0));
      check("req_ready", 32'(req_ready), 32'((exp_q.size() == 0) || rsp_ready));
      if (exp_q.size() != 0) begin
        check("rsp_rdata", rsp_rdata, exp_q[0][31:0]);
        check("rsp_err", 32'(rsp_err), 32'(exp_q[0][32]));
      end
      for (int k = 0; k < N_OUT; k++) check("io_out", io_out[32*k +: 32], m_out[k]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic xact(input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rd, output logic er);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; rsp_ready = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      n_cmp++; n_bad++;
      $display("FAIL xact_timeout: req_ready stayed %b, required 1", req_ready);
    end
    @(posedge clk);
    #2;
    rd = rsp_rdata;
    er = rsp_err;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic load_chk(input string name, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] rd;
    logic        er;
    xact(1'b0, size, uns, addr, 32'h0, rd, er);
    check(name, rd, exp);
    check({name, "_err"}, 32'(er), 32'h0);
  endtask

  task automatic err_chk(input string name, input logic we, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] rd;
    logic        er;
    xact(we, size, 1'b0, addr, wdata, rd, er);
    check(name, 32'(er), 32'h1);
    check({name, "_rdata"}, rd, 32'h0);
  endtask

  // Wait for the pending response to drain, then leave a stalled load of addr.
  task automatic stalled_load(input logic [31:0] addr);
    @(negedge clk);
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = addr; rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish before 1000000");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  logic [31:0] rd;
  logic        er;
  logic [31:0] a;

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b1; io_sw = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_err", 32'(rsp_err), 32'h0);
    check("rst_req_ready", 32'(req_ready), 32'h1);
    check("rst_io_out0", io_out[31:0], 32'h0);

    // Clear the whole data memory with back-to-back word stores.
    for (int i = 0; i < 2**DEPTH_W; i++) begin
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'(4 * i);
      req_wdata = 32'h0; rsp_ready = 1'b1;
    end
    @(negedge clk);
    req_valid = 1'b0;

    // Sub-word loads from a stored word.
    xact(1'b1, 2'd2, 1'b0, 32'h004, 32'hDEADBEEF, rd, er);
    check("sw_err", 32'(er), 32'h0);
    check("sw_rdata", rd, 32'h0);
    load_chk("lbu_005", 2'd0, 1'b1, 32'h005, 32'h000000BE);
    load_chk("lb_007", 2'd0, 1'b0, 32'h007, 32'hFFFFFFDE);
    load_chk("lh_006", 2'd1, 1'b0, 32'h006, 32'hFFFFDEAD);
    load_chk("lhu_004", 2'd1, 1'b1, 32'h004, 32'h0000BEEF);

    // Byte store into an output register.
    xact(1'b1, 2'd0, 1'b0, OUT_BASE + 32'd8, 32'h0000005A, rd, er);
    check("out2", io_out[2*32 +: 32], 32'h0000005A);
    check("out0", io_out[31:0], 32'h0);
    check("out3", io_out[3*32 +: 32], 32'h0);

    // Faulting accesses leave all state untouched.
    err_chk("lw_mis", 1'b0, 2'd2, 32'h002, 32'h0);
    err_chk("sh_mis", 1'b1, 2'd1, 32'h001, 32'h0000FFFF);
    err_chk("size3", 1'b1, 2'd3, 32'h000, 32'hFFFFFFFF);
    err_chk("unmapped_ld", 1'b0, 2'd2, 32'h00000C00, 32'h0);
    err_chk("unmapped_st", 1'b1, 2'd2, 32'h00000C00, 32'h12345678);
    load_chk("mem0_kept", 2'd2, 1'b0, 32'h000, 32'h0);
    load_chk("mem4_kept", 2'd2, 1'b0, 32'h004, 32'hDEADBEEF);
    load_chk("mem100_kept", 2'd2, 1'b0, 32'h400, 32'h0);

    // Response stall for three cycles, then a release together with a new request.
    stalled_load(32'h004);
    for (int i = 0; i < 3; i++) begin
      check("stall_ready", 32'(req_ready), 32'h0);
      check("stall_valid", 32'(rsp_valid), 32'h1);
      check("stall_rdata", rsp_rdata, 32'hDEADBEEF);
      @(negedge clk);
    end
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b1;
    req_addr = 32'h005; rsp_ready = 1'b1;
    #1;
    check("release_ready", 32'(req_ready), 32'h1);
    @(posedge clk);
    #2;
    check("release_valid", 32'(rsp_valid), 32'h1);
    check("release_rdata", rsp_rdata, 32'h000000BE);
    @(negedge clk);
    req_valid = 1'b0;

    // Switch synchroniser latency.
    @(posedge clk);
    #3;
    io_sw = 32'h000000F3;
    load_chk("sw_early", 2'd2, 1'b0, IN_BASE, 32'h0);
    load_chk("sw_late", 2'd2, 1'b0, IN_BASE, 32'h000000F3);
    load_chk("sw_byte", 2'd0, 1'b0, IN_BASE, 32'hFFFFFFF3);
    err_chk("st_in", 1'b1, 2'd2, IN_BASE, 32'h1);

    // Reset while a response is stalled; a request presented during reset is dropped.
    stalled_load(32'h004);
    rst_n = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h004;
    req_wdata = 32'h11111111;
    @(posedge clk);
    #2;
    check("rstall_valid", 32'(rsp_valid), 32'h0);
    check("rstall_out2", io_out[2*32 +: 32], 32'h0);
    check("rstall_ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    rst_n = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
    load_chk("mem4_after_rst", 2'd2, 1'b0, 32'h004, 32'hDEADBEEF);
    load_chk("sw_after_rst", 2'd2, 1'b0, IN_BASE, 32'h000000F3);

    // Randomized traffic checked by the model.
    for (int c = 0; c < 2500; c++) begin
      @(negedge clk);
      req_valid    = $urandom_range(0, 3) != 0;
      rsp_ready    = $urandom_range(0, 3) != 0;
      req_we       = $urandom_range(0, 1) == 1;
      req_unsigned = $urandom_range(0, 1) == 1;
      req_size     = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      req_wdata    = $urandom;
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: a = 32'($urandom_range(0, 2047));
        6, 7:             a = OUT_BASE + 32'($urandom_range(0, 47));
        8:                a = IN_BASE + 32'($urandom_range(0, 3));
        default:          a = $urandom;
      endcase
      if (req_size != 2'd3 && $urandom_range(0, 3) != 0) a = a & ~((32'h1 << req_size) - 32'h1);
      req_addr = a;
      if ($urandom_range(0, 19) == 0) io_sw = $urandom;
    end
    @(negedge clk);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
